// File: rtl/mist32e10fa_arbiter_2to1_ordered.sv
// Two-master to one-slave request arbiter with in-order response return.
// Requests are granted round-robin into a registered slave request stage.
// The winning master ID is recorded in an ordering FIFO so each slave
// response can be steered back to the master that issued the request.
module mist32e10fa_arbiter_2to1_ordered #(
   parameter int AW = 32,
   parameter int DW = 32,
   parameter int D  = 8,
   parameter int DN = 3
) (
   input  logic          iCLOCK,
   input  logic          inRESET,
   input  logic          iFLASH,
   // Master 0
   input  logic          iM0_REQ,
   output logic          oM0_BUSY,
   input  logic          iM0_RW,
   input  logic [AW-1:0] iM0_ADDR,
   input  logic [DW-1:0] iM0_DATA,
   output logic          oM0_VALID,
   output logic [DW-1:0] oM0_DATA,
   // Master 1
   input  logic          iM1_REQ,
   output logic          oM1_BUSY,
   input  logic          iM1_RW,
   input  logic [AW-1:0] iM1_ADDR,
   input  logic [DW-1:0] iM1_DATA,
   output logic          oM1_VALID,
   output logic [DW-1:0] oM1_DATA,
   // Slave
   output logic          oS_REQ,
   input  logic          iS_BUSY,
   output logic          oS_RW,
   output logic [AW-1:0] oS_ADDR,
   output logic [DW-1:0] oS_DATA,
   input  logic          iS_VALID,
   input  logic [DW-1:0] iS_DATA
);

   // Registered slave request stage
   logic          sReq_q,  sReq_d;
   logic          sRw_q,   sRw_d;
   logic [AW-1:0] sAddr_q, sAddr_d;
   logic [DW-1:0] sData_q, sData_d;

   // Ordering FIFO pointers carry one extra wrap bit
   logic [DN:0]   wr_q, wr_d;
   logic [DN:0]   rd_q, rd_d;
   logic          orderFifo_q [D];

   // Master that won most recently; the other one has priority on a tie
   logic          lastGrant_q, lastGrant_d;

   logic [DN:0]   count;
   logic          full;
   logic          empty;
   logic          stageFree;
   logic          canGrant;
   logic          grant0;
   logic          grant1;
   logic          head;
   logic          pop;

   // Occupancy is derived from the registered pointers only, so a pop in
   // the current cycle never frees a slot for a grant in the same cycle.
   assign count     = wr_q - rd_q;
   assign full      = (count == (DN+1)'(D));
   assign empty     = (wr_q == rd_q);

   // The stage can take a new request when it holds nothing or the slave
   // is consuming what it holds this cycle.
   assign stageFree = !sReq_q || !iS_BUSY;
   assign canGrant  = stageFree && !full && !iFLASH;

   // Round-robin: a lone requester wins; on a tie the non-last master wins.
   assign grant0    = canGrant && iM0_REQ && (!iM1_REQ || lastGrant_q);
   assign grant1    = canGrant && iM1_REQ && (!iM0_REQ || !lastGrant_q);

   assign oM0_BUSY  = !grant0;
   assign oM1_BUSY  = !grant1;

   // A response is matched to the oldest outstanding entry; responses that
   // arrive with nothing outstanding (or during a flash) are dropped.
   assign head      = orderFifo_q[rd_q[DN-1:0]];
   assign pop       = iS_VALID && !empty && !iFLASH;

   assign oM0_VALID = pop && !head;
   assign oM1_VALID = pop && head;
   assign oM0_DATA  = iS_DATA;
   assign oM1_DATA  = iS_DATA;

   assign oS_REQ    = sReq_q;
   assign oS_RW     = sRw_q;
   assign oS_ADDR   = sAddr_q;
   assign oS_DATA   = sData_q;

   // Next-state for the request stage, FIFO pointers and round-robin pointer
   always_comb begin
      sReq_d      = sReq_q;
      sRw_d       = sRw_q;
      sAddr_d     = sAddr_q;
      sData_d     = sData_q;
      wr_d        = wr_q;
      rd_d        = rd_q;
      lastGrant_d = lastGrant_q;

      if (iFLASH) begin
         sReq_d = 1'b0;
         wr_d   = '0;
         rd_d   = '0;
      end else begin
         if (grant0 || grant1) begin
            sReq_d      = 1'b1;
            sRw_d       = grant1 ? iM1_RW   : iM0_RW;
            sAddr_d     = grant1 ? iM1_ADDR : iM0_ADDR;
            sData_d     = grant1 ? iM1_DATA : iM0_DATA;
            wr_d        = wr_q + 1'b1;
            lastGrant_d = grant1;
         end else if (!iS_BUSY) begin
            sReq_d = 1'b0;
         end
         if (pop) begin
            rd_d = rd_q + 1'b1;
         end
      end
   end

   // State registers, cleared asynchronously; master 0 gets first priority
   always_ff @(posedge iCLOCK or negedge inRESET) begin
      if (!inRESET) begin
         sReq_q      <= 1'b0;
         sRw_q       <= 1'b0;
         sAddr_q     <= '0;
         sData_q     <= '0;
         wr_q        <= '0;
         rd_q        <= '0;
         lastGrant_q <= 1'b1;
      end else begin
         sReq_q      <= sReq_d;
         sRw_q       <= sRw_d;
         sAddr_q     <= sAddr_d;
         sData_q     <= sData_d;
         wr_q        <= wr_d;
         rd_q        <= rd_d;
         lastGrant_q <= lastGrant_d;
      end
   end

   // Record the winning master ID at the write slot on every grant
   always_ff @(posedge iCLOCK or negedge inRESET) begin
      if (!inRESET) begin
         for (int i = 0; i < D; i++) begin
            orderFifo_q[i] <= 1'b0;
         end
      end else if (grant0 || grant1) begin
         orderFifo_q[wr_q[DN-1:0]] <= grant1;
      end
   end

endmodule
